dot_product_accumulator: RTL and testbench

Sequential accumulator directly downstream of the 32x32 Vedic multiplier in the matrix-multiplier datapath. It takes one product per valid cycle from the multiplier's `result`/`done` outputs and sums `N_TERMS` consecutive products into one dot-product element. It then presents the sum with a one-cycle `done` pulse to the result-write stage.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/dot_product_accumulator.sv | 89 ++++++++
 tb/tb_dot_product_accumulator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier datapath: accumulator FSM
// states, a constant-foldable ceiling-log2 and the default datapath sizes.
package mm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    localparam int MM_PROD_W  = 64;
    localparam int MM_N_TERMS = 4;

    // Ceiling log2; clog2(1) = 0 so a single-term build needs no growth bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_product_accumulator.sv
// Sums N_TERMS consecutive unsigned products from the multiplier into one
// dot-product element and presents it with a single-cycle done pulse.
module dot_product_accumulator
    import mm_pkg::*;
#(
    parameter int PROD_W  = MM_PROD_W,
    parameter int N_TERMS = MM_N_TERMS,
    parameter int ACC_W   = PROD_W + clog2(N_TERMS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [PROD_W-1:0] product_i,
    input  logic              do_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int               CNT_W    = clog2(N_TERMS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               accept;
    logic [ACC_W-1:0]   acc_base, acc_next;
    logic [CNT_W-1:0]   cnt_base, cnt_next;

    always_comb begin
        // A start discards any partial sum, so the term it carries (if any)
        // is added onto zero rather than onto the old accumulator.
        accept   = do_i && (start_i || (state_q == ACC));
        acc_base = start_i ? '0 : acc_q;
        cnt_base = start_i ? '0 : cnt_q;
        acc_next = acc_base + ACC_W'(product_i);
        cnt_next = cnt_base + CNT_W'(1);

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        done_d  = 1'b0;

        if (start_i) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end

        if (accept) begin
            if (cnt_next == LAST_CNT) begin
                sum_d   = acc_next;
                done_d  = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                acc_d   = acc_next;
                cnt_d   = cnt_next;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign sum_o  = sum_q;
    assign done_o = done_q;
    assign busy_o = (state_q == ACC);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: a 4-term instance checked against a
// queue-based reference model, plus a 1-term instance for immediate completion.
module tb_dot_product_accumulator;
    import mm_pkg::*;

    localparam int PW  = 64;
    localparam int NT  = 4;
    localparam int AW  = PW + clog2(NT);
    localparam logic [PW-1:0] BIG = 64'hFFFF_FFFE_0000_0001;

    logic          clk = 1'b0;
    logic          reset_i, start_i, do_i;
    logic [PW-1:0] product_i;
    logic [AW-1:0] sum_o;
    logic          done_o, busy_o;

    logic          s1, d1;
    logic [PW-1:0] p1;
    logic [PW-1:0] sum1;
    logic          done1, busy1;

    int checks = 0;
    int errors = 0;

    // Reference model: products accepted since the last start.
    logic [PW-1:0] terms[$];
    bit            m_active;
    logic [AW-1:0] m_sum;
    bit            m_done;

    always #5 clk = ~clk;

    dot_product_accumulator #(.PROD_W(PW), .N_TERMS(NT)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .product_i(product_i),
        .do_i(do_i), .sum_o(sum_o), .done_o(done_o), .busy_o(busy_o)
    );

    dot_product_accumulator #(.PROD_W(PW), .N_TERMS(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .start_i(s1), .product_i(p1),
        .do_i(d1), .sum_o(sum1), .done_o(done1), .busy_o(busy1)
    );

    task automatic model_clear();
        terms.delete();
        m_active = 0;
        m_sum    = '0;
        m_done   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, return at posedge+1.
    task automatic cycle(input bit s, input bit d, input logic [PW-1:0] p);
        logic [AW-1:0] total;
        start_i   = s;
        do_i      = d;
        product_i = p;
        m_done    = 0;
        if (s) begin
            m_active = 1;
            terms.delete();
        end
        if (d && m_active) begin
            terms.push_back(p);
            if (terms.size() == NT) begin
                total = '0;
                foreach (terms[k]) total = total + AW'(terms[k]);
                m_sum    = total;
                m_done   = 1;
                m_active = 0;
                terms.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 0; do_i = 0; product_i = '0;
        s1 = 0; d1 = 0; p1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (sum_o !== '0)   begin errors++; $display("FAIL reset_sum got %h expected 0", sum_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
        reset_i = 1'b0;
        model_clear();
    endtask

    task automatic test_idle_drop();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 64'd5);
            checks += 3;
            if (sum_o !== '0)    begin errors++; $display("FAIL idle_sum cyc %0d got %h expected 0", i, sum_o); end
            if (done_o !== 1'b0) begin errors++; $display("FAIL idle_done cyc %0d got %b expected 0", i, done_o); end
            if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy cyc %0d got %b expected 0", i, busy_o); end
        end
        $display("idle: do without start dropped, sum=%h", sum_o);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 1, PW'(i + 1));
            checks += 2;
            if (done_o !== m_done)   begin errors++; $display("FAIL basic_done term %0d got %b expected %b", i, done_o, m_done); end
            if (busy_o !== m_active) begin errors++; $display("FAIL basic_busy term %0d got %b expected %b", i, busy_o, m_active); end
        end
        checks += 1;
        if (sum_o !== AW'(10)) begin errors++; $display("FAIL basic_sum got %h expected %h", sum_o, AW'(10)); end
        cycle(0, 0, '0);
        checks += 2;
        if (done_o !== 1'b0)   begin errors++; $display("FAIL basic_pulse got done=%b expected 0", done_o); end
        if (sum_o !== AW'(10)) begin errors++; $display("FAIL basic_hold got %h expected %h", sum_o, AW'(10)); end
        $display("basic: 1+2+3+4 sum=%0d", sum_o);
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 1, BIG);
            checks += 2;
            if (done_o !== m_done) begin errors++; $display("FAIL gap_done term %0d got %b expected %b", i, done_o, m_done); end
            if (busy_o !== m_active) begin errors++; $display("FAIL gap_busy term %0d got %b expected %b", i, busy_o, m_active); end
            if (i < 3) begin
                repeat (2) begin
                    cycle(0, 0, BIG);
                    checks += 1;
                    if (done_o !== 1'b0) begin errors++; $display("FAIL gap_stall got done=%b expected 0", done_o); end
                end
            end
        end
        checks += 1;
        if (sum_o !== 66'h3_FFFF_FFF8_0000_0004) begin
            errors++; $display("FAIL gap_sum got %h expected %h", sum_o, 66'h3_FFFF_FFF8_0000_0004);
        end
        $display("gapped: 4 x max product sum=%h", sum_o);
    endtask

    task automatic test_abort();
        logic [AW-1:0] prior;
        int dones;
        prior = m_sum;
        dones = 0;
        cycle(1, 0, '0);
        cycle(0, 1, 64'd7);
        cycle(0, 1, 64'd7);
        checks += 2;
        if (sum_o !== prior) begin errors++; $display("FAIL abort_hold got %h expected %h", sum_o, prior); end
        if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy got %b expected 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 1, 64'd1);
            if (done_o === 1'b1) dones++;
            checks += 1;
            if (i < 3 && sum_o !== prior) begin errors++; $display("FAIL abort_hold2 term %0d got %h expected %h", i, sum_o, prior); end
        end
        checks += 2;
        if (dones != 1)       begin errors++; $display("FAIL abort_dones got %0d expected 1", dones); end
        if (sum_o !== AW'(4)) begin errors++; $display("FAIL abort_sum got %h expected 4", sum_o); end
        $display("abort: restarted dot product sum=%0d dones=%0d", sum_o, dones);
    endtask

    task automatic test_async_reset();
        cycle(1, 1, 64'd3);
        cycle(0, 1, 64'd3);
        #3;
        reset_i = 1'b1;
        #1;
        checks += 3;
        if (sum_o !== '0)    begin errors++; $display("FAIL areset_sum got %h expected 0", sum_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy got %b expected 0", busy_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL areset_done got %b expected 0", done_o); end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        model_clear();
        cycle(0, 0, '0);
        checks += 1;
        if (done_o !== 1'b0) begin errors++; $display("FAIL areset_release_done got %b expected 0", done_o); end
        for (int i = 0; i < 4; i++) cycle(i == 0, 1, 64'd3);
        checks += 2;
        if (done_o !== 1'b1)   begin errors++; $display("FAIL areset_after_done got %b expected 1", done_o); end
        if (sum_o !== AW'(12)) begin errors++; $display("FAIL areset_after_sum got %h expected 12", sum_o); end
        $display("async reset: cleared mid-run, next sum=%0d", sum_o);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(i == 0, 1, {$urandom, $urandom});
                checks += 3;
                if (done_o !== m_done)   begin errors++; $display("FAIL b2b_done set %0d term %0d got %b expected %b", n, i, done_o, m_done); end
                if (busy_o !== m_active) begin errors++; $display("FAIL b2b_busy set %0d term %0d got %b expected %b", n, i, busy_o, m_active); end
                if (sum_o !== m_sum)     begin errors++; $display("FAIL b2b_sum set %0d term %0d got %h expected %h", n, i, sum_o, m_sum); end
            end
            $display("back_to_back: set %0d sum=%h", n, sum_o);
        end
    endtask

    task automatic test_n1();
        s1 = 1; d1 = 1; p1 = 64'd9;
        @(posedge clk); #1;
        checks += 3;
        if (done1 !== 1'b1)   begin errors++; $display("FAIL n1_done0 got %b expected 1", done1); end
        if (sum1 !== 64'd9)   begin errors++; $display("FAIL n1_sum0 got %h expected 9", sum1); end
        if (busy1 !== 1'b0)   begin errors++; $display("FAIL n1_busy0 got %b expected 0", busy1); end
        p1 = 64'd10;
        @(posedge clk); #1;
        checks += 2;
        if (done1 !== 1'b1)   begin errors++; $display("FAIL n1_done1 got %b expected 1", done1); end
        if (sum1 !== 64'd10)  begin errors++; $display("FAIL n1_sum1 got %h expected 10", sum1); end
        s1 = 0; d1 = 1; p1 = 64'd77;
        @(posedge clk); #1;
        checks += 2;
        if (done1 !== 1'b0)   begin errors++; $display("FAIL n1_drop_done got %b expected 0", done1); end
        if (sum1 !== 64'd10)  begin errors++; $display("FAIL n1_drop_sum got %h expected 10", sum1); end
        d1 = 0;
        $display("n_terms=1: back-to-back sums 9,10 then dropped do, sum=%0d", sum1);
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        bit s, d;
        int dones;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            cycle(s, d, p);
            if (m_done) dones++;
            checks += 3;
            if (done_o !== m_done)   begin errors++; $display("FAIL rand_done cyc %0d got %b expected %b", i, done_o, m_done); end
            if (busy_o !== m_active) begin errors++; $display("FAIL rand_busy cyc %0d got %b expected %b", i, busy_o, m_active); end
            if (sum_o !== m_sum)     begin errors++; $display("FAIL rand_sum cyc %0d got %h expected %h", i, sum_o, m_sum); end
        end
        $display("random: 300 cycles, %0d completions, last sum=%h", dones, sum_o);
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_basic();
        test_gapped();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_n1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
